// File: rtl/crc_rr_sched.sv
// Round-robin scheduler that hands one job at a time to a shared CRC engine,
// aborts the job if the engine stalls, and returns the result to its owner.
module crc_rr_sched #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  input  logic [NREQ*(WIDTH+1)-1:0] req_poly,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [WIDTH-1:0]          rsp_crc,
  output logic                      rsp_err,
  output logic                      eng_start,
  output logic [WIDTH-1:0]          eng_data,
  output logic [WIDTH:0]            eng_poly,
  input  logic                      eng_done,
  input  logic [WIDTH-1:0]          eng_crc,
  output logic                      busy,
  output logic [15:0]               jobs_done
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   grant;
  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   win;
  logic [WIDTH-1:0]   sel_data;
  logic [WIDTH:0]     sel_poly;

  // First requester with valid set, searching upward from p and wrapping.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] idx;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PTR_W'((int'(p) + i) % NREQ);
      if (!found && v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign win  = rr_pick(req_valid, ptr);
  assign busy = (state != IDLE);

  always_comb begin
    sel_data = '0;
    sel_poly = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == PTR_W'(i)) begin
        sel_data = req_data[i*WIDTH +: WIDTH];
        sel_poly = req_poly[i*(WIDTH+1) +: WIDTH+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant     <= '0;
      cnt       <= '0;
      jobs_done <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_crc   <= '0;
      rsp_err   <= 1'b0;
      eng_start <= 1'b0;
      eng_data  <= '0;
      eng_poly  <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      eng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant     <= win;
            eng_data  <= sel_data;
            eng_poly  <= sel_poly;
            req_ready <= onehot(win);
            eng_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          ptr   <= (grant == PTR_W'(NREQ - 1)) ? '0 : grant + 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          // A done arriving on the final timeout cycle still counts as success.
          if (eng_done) begin
            rsp_crc   <= eng_crc;
            rsp_err   <= 1'b0;
            rsp_valid <= onehot(grant);
            state     <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            rsp_crc   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= onehot(grant);
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (!rsp_err) jobs_done <= jobs_done + 16'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_rr_sched.sv
// Bench for crc_rr_sched: directed vector table, corner sequences, and
// randomized jobs checked against a round-robin/timeout reference model.
module tb_crc_rr_sched;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int TO = 63;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*W-1:0]    req_data;
  logic [N*(W+1)-1:0] req_poly;
  logic [N-1:0]      req_ready, rsp_valid;
  logic [W-1:0]      rsp_crc, eng_data, eng_crc;
  logic              rsp_err, eng_start, eng_done, busy;
  logic [W:0]        eng_poly;
  logic [15:0]       jobs_done;

  logic [W-1:0] dat[N];
  logic [W:0]   pol[N];

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign req_data[i*W +: W]         = dat[i];
    assign req_poly[i*(W+1) +: W+1]   = pol[i];
  end

  crc_rr_sched #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_poly(req_poly), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_crc(rsp_crc), .rsp_err(rsp_err), .eng_start(eng_start),
    .eng_data(eng_data), .eng_poly(eng_poly), .eng_done(eng_done),
    .eng_crc(eng_crc), .busy(busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Engine model: one-cycle done pulse 'eng_delay' cycles after the start
  // pulse; a delay of 0 means the engine never answers.
  int           eng_delay = 0;
  logic [W-1:0] eng_val = '0;
  int           cd = 0;
  initial begin
    eng_done = 1'b0;
    eng_crc  = '0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (eng_start) cd = eng_delay;
      else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          eng_done = 1'b1;
          eng_crc  = eng_val;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0 && i < N) v = N'(1) << i;
    return v;
  endfunction

  function automatic int oh2i(input logic [N-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  logic [N-1:0] rdy, rsp;
  int           t_rdy, t_rsp;
  logic [W-1:0] crc, ed;
  logic [W:0]   ep;
  logic         err, es;

  // Issues one job from the IDLE cycle (cycle 0) and returns in the IDLE
  // cycle that follows the response.
  task automatic run_job(input logic [N-1:0] mask, input int d, input logic [W-1:0] v);
    int t;
    t = 0; t_rdy = -1; t_rsp = -1; rdy = '0; rsp = '0;
    crc = '0; err = 1'b0; ed = '0; ep = '0; es = 1'b0;
    eng_delay = d; eng_val = v; req_valid = mask;
    while (t < 200 && t_rsp < 0) begin
      @(negedge clk);
      t++;
      if (t_rdy < 0 && req_ready != '0) begin
        t_rdy = t; rdy = req_ready; ed = eng_data; ep = eng_poly; es = eng_start;
        req_valid = '0;
      end
      if (rsp_valid != '0) begin
        t_rsp = t; rsp = rsp_valid; crc = rsp_crc; err = rsp_err;
      end
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; eng_delay = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] mask;
    int           d;
    logic [W-1:0] v;
    int           g;
    int           t_rsp;
    logic         err;
    logic [W-1:0] crc;
    int           jobs;
  } vec_t;
  vec_t tbl[9];

  int           bad, ng;
  int           gi[5], ts[5];
  int           mptr, mjobs, eg, et, d, r;
  logic         ok;
  logic [W-1:0] v, ecrc;
  logic [N-1:0] mask;

  initial begin
    tbl[0] = '{4'b0001,  5, 32'hDEADBEEF, 0,  7, 1'b0, 32'hDEADBEEF, 1};
    tbl[1] = '{4'b1111,  1, 32'h00000011, 1,  3, 1'b0, 32'h00000011, 2};
    tbl[2] = '{4'b1111,  2, 32'h00000022, 2,  4, 1'b0, 32'h00000022, 3};
    tbl[3] = '{4'b1111,  3, 32'h00000033, 3,  5, 1'b0, 32'h00000033, 4};
    tbl[4] = '{4'b1111,  1, 32'h00000044, 0,  3, 1'b0, 32'h00000044, 5};
    tbl[5] = '{4'b0001,  1, 32'h00000055, 0,  3, 1'b0, 32'h00000055, 6};
    tbl[6] = '{4'b1000, 64, 32'hCAFEF00D, 3, 66, 1'b0, 32'hCAFEF00D, 7};
    tbl[7] = '{4'b0110,  0, 32'h12121212, 1, 66, 1'b1, 32'h00000000, 7};
    tbl[8] = '{4'b0100, 65, 32'h34343434, 2, 66, 1'b1, 32'h00000000, 7};

    dat[0] = 32'h12345678; pol[0] = 33'h104C11DB7;
    dat[1] = 32'hA5A5A5A5; pol[1] = 33'h11EDC6F41;
    dat[2] = 32'h0F0F0F0F; pol[2] = 33'h1741B8CD7;
    dat[3] = 32'hFFFFFFFF; pol[3] = 33'h1814141AB;

    // Reset state
    rst = 1'b0; req_valid = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_crc",   64'(rsp_crc),   64'(0));
    check("rst_rsp_err",   64'(rsp_err),   64'(0));
    check("rst_eng_start", 64'(eng_start), 64'(0));
    check("rst_eng_data",  64'(eng_data),  64'(0));
    check("rst_eng_poly",  64'(eng_poly),  64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    check("rst_jobs_done", 64'(jobs_done), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int k = 0; k < 9; k++) begin
      run_job(tbl[k].mask, tbl[k].d, tbl[k].v);
      check("tbl_ready",     64'(rdy),      64'(oh(tbl[k].g)));
      check("tbl_t_ready",   64'(t_rdy),    64'(1));
      check("tbl_eng_start", 64'(es),       64'(1));
      check("tbl_eng_data",  64'(ed),       64'(dat[tbl[k].g]));
      check("tbl_eng_poly",  64'(ep),       64'(pol[tbl[k].g]));
      check("tbl_t_rsp",     64'(t_rsp),    64'(tbl[k].t_rsp));
      check("tbl_rsp_valid", 64'(rsp),      64'(oh(tbl[k].g)));
      check("tbl_rsp_err",   64'(err),      64'(tbl[k].err));
      check("tbl_rsp_crc",   64'(crc),      64'(tbl[k].crc));
      check("tbl_jobs_done", 64'(jobs_done), 64'(tbl[k].jobs));
      check("tbl_busy_idle", 64'(busy),     64'(0));
    end

    // Timeout followed by a late done at cycle 70
    run_job(4'b0001, 69, 32'h11111111);
    check("late_ready", 64'(rdy),   64'(oh(0)));
    check("late_t_rsp", 64'(t_rsp), 64'(66));
    check("late_err",   64'(err),   64'(1));
    check("late_crc",   64'(crc),   64'(0));
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid != '0 || busy) bad++;
    end
    check("late_done_ignored", 64'(bad), 64'(0));
    check("late_jobs_done", 64'(jobs_done), 64'(7));

    // All requesters held continuously
    do_reset();
    req_valid = 4'b1111; eng_delay = 1; eng_val = 32'h600DF00D;
    ng = 0;
    for (int t = 1; t <= 60 && ng < 5; t++) begin
      @(negedge clk);
      if (eng_start) begin
        gi[ng] = oh2i(req_ready);
        ts[ng] = t;
        ng++;
      end
    end
    req_valid = '0;
    repeat (6) @(negedge clk);
    check("rr_grants_seen", 64'(ng), 64'(5));
    for (int k = 0; k < 5; k++) begin
      check("rr_grant_order", 64'(gi[k]), 64'(k % N));
      if (k > 0) check("rr_start_spacing", 64'(ts[k] - ts[k-1]), 64'(4));
    end

    // Reset in the middle of a job
    req_valid = 4'b0010; eng_delay = 0;
    repeat (4) @(negedge clk);
    req_valid = '0;
    check("mid_busy_before", 64'(busy), 64'(1));
    rst = 1'b0;
    @(negedge clk);
    check("mid_rsp_crc",   64'(rsp_crc),   64'(0));
    check("mid_eng_data",  64'(eng_data),  64'(0));
    check("mid_eng_poly",  64'(eng_poly),  64'(0));
    check("mid_busy",      64'(busy),      64'(0));
    check("mid_outputs",   64'({req_ready, rsp_valid, rsp_err, eng_start}), 64'(0));
    check("mid_jobs_done", 64'(jobs_done), 64'(0));
    rst = 1'b1;
    bad = 0;
    repeat (70) begin
      @(negedge clk);
      if (rsp_valid != '0 || busy) bad++;
    end
    check("mid_no_rsp", 64'(bad), 64'(0));
    run_job(4'b0101, 2, 32'h0BADCAFE);
    check("mid_ptr_zero", 64'(rdy), 64'(oh(0)));
    run_job(4'b0100, 3, 32'h5EED1234);
    check("mid_req2_ready", 64'(rdy),   64'(oh(2)));
    check("mid_req2_t_rsp", 64'(t_rsp), 64'(5));
    check("mid_req2_rsp",   64'(rsp),   64'(oh(2)));
    check("mid_req2_crc",   64'(crc),   64'(32'h5EED1234));
    check("mid_req2_err",   64'(err),   64'(0));
    check("mid_req2_jobs",  64'(jobs_done), 64'(2));

    // Randomized jobs against the reference model
    do_reset();
    @(negedge clk);
    mptr = 0; mjobs = 0;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < N; i++) begin
        dat[i] = $urandom();
        pol[i] = {1'b1, $urandom()};
      end
      mask = N'($urandom_range(1, 15));
      v    = $urandom();
      r    = $urandom_range(0, 9);
      d    = (r == 0) ? 0 : (r == 1) ? TO + 1 : (r == 2) ? TO + 2 : $urandom_range(1, 12);
      eg = -1;
      for (int k = 0; k < N; k++)
        if (eg < 0 && mask[(mptr + k) % N]) eg = (mptr + k) % N;
      mptr  = (eg + 1) % N;
      ok    = (d >= 1 && d <= TO + 1);
      et    = ok ? d + 2 : TO + 3;
      ecrc  = ok ? v : '0;
      if (ok) mjobs = (mjobs + 1) % 65536;
      run_job(mask, d, v);
      check("rnd_ready",     64'(rdy),       64'(oh(eg)));
      check("rnd_eng_data",  64'(ed),        64'(dat[eg]));
      check("rnd_eng_poly",  64'(ep),        64'(pol[eg]));
      check("rnd_t_rsp",     64'(t_rsp),     64'(et));
      check("rnd_rsp_valid", 64'(rsp),       64'(oh(eg)));
      check("rnd_rsp_err",   64'(err),       64'(!ok));
      check("rnd_rsp_crc",   64'(crc),       64'(ecrc));
      check("rnd_jobs_done", 64'(jobs_done), 64'(mjobs));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // jobs_done wrap from 0xFFFF
    force dut.jobs_done = 16'hFFFF;
    @(negedge clk);
    release dut.jobs_done;
    @(negedge clk);
    check("wrap_preload", 64'(jobs_done), 64'(16'hFFFF));
    run_job(4'b0001, 1, 32'h77777777);
    check("wrap_err",  64'(err),       64'(0));
    check("wrap_jobs", 64'(jobs_done), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
